// File: rtl/left_shift_seq.sv
// Multi-cycle left shift/rotate unit: one bit position per clock.
// Ports: CLK, RESET (sync, active-low), START, DATA1 (value),
//   DATA2 (control: [7:6] mode, [3:0] amount), BUSY, DONE, RESULT.
module left_shift_seq (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RESULT
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        FIN   = 2'b10
    } state_t;

    localparam logic [1:0] MODE_LOG  = 2'b00;
    localparam logic [1:0] MODE_ARI  = 2'b01;
    localparam logic [1:0] MODE_ROT  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    state_t     state, state_n;
    logic [7:0] sr, sr_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] mode, mode_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic [7:0] result, result_n;
    logic [7:0] step;
    logic       accept;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state  <= IDLE;
            sr     <= 8'h00;
            cnt    <= 4'd0;
            mode   <= MODE_LOG;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 8'h00;
        end else begin
            state  <= state_n;
            sr     <= sr_n;
            cnt    <= cnt_n;
            mode   <= mode_n;
            busy   <= busy_n;
            done   <= done_n;
            result <= result_n;
        end
    end

    // One step of the selected left operation on the shift register.
    always_comb begin
        step = sr;
        case (mode)
            MODE_LOG: step = {sr[6:0], 1'b0};
            MODE_ARI: step = {sr[7], sr[5:0], 1'b0};
            MODE_ROT: step = {sr[6:0], sr[7]};
            default:  step = sr;
        endcase
    end

    // The FIN cycle's closing edge doubles as the earliest acceptance
    // edge, giving N+1 cycle back-to-back throughput.
    assign accept = START && (state != SHIFT);

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        cnt_n    = cnt;
        mode_n   = mode;
        busy_n   = busy;
        done_n   = 1'b0;
        result_n = result;
        case (state)
            IDLE, FIN: begin
                busy_n  = 1'b0;
                state_n = IDLE;
                if (accept) begin
                    sr_n   = DATA1;
                    cnt_n  = DATA2[3:0];
                    mode_n = DATA2[7:6];
                    busy_n = 1'b1;
                    if (DATA2[3:0] == 4'd0 || DATA2[7:6] == MODE_PASS) begin
                        state_n  = FIN;
                        done_n   = 1'b1;
                        result_n = DATA1;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sr_n  = step;
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    result_n = step;
                    done_n   = 1'b1;
                    state_n  = FIN;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    assign BUSY   = busy;
    assign DONE   = done;
    assign RESULT = result;

endmodule

// File: tb/tb_left_shift_seq.sv
// Self-checking bench for left_shift_seq: directed and random ops
// compared against an arithmetic reference model.
module tb_left_shift_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic       BUSY;
    logic       DONE;
    logic [7:0] RESULT;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    left_shift_seq dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    function automatic logic [7:0] ref_model(input logic [7:0] d,
                                             input logic [7:0] c);
        int n;
        int k;
        int v;
        n = int'(c[3:0]);
        v = int'(d);
        if (n == 0 || c[7:6] == 2'b11) return d;
        case (c[7:6])
            2'b00: return 8'((v << n) & 255);
            2'b01: return 8'((v & 128) | ((v << n) & 127));
            default: begin
                k = n % 8;
                return 8'(((v << k) | (v >> (8 - k))) & 255);
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] d1, input logic [7:0] d2,
                          input string tag);
        int lat;
        logic [7:0] exp;
        logic [7:0] prev;
        @(negedge CLK);
        START = 1'b1;
        DATA1 = d1;
        DATA2 = d2;
        prev = RESULT;
        lat = (d2[3:0] == 4'd0 || d2[7:6] == 2'b11) ? 0 : int'(d2[3:0]);
        exp = ref_model(d1, d2);
        for (int k = 0; k <= lat; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) begin
                START = 1'b0;
                DATA1 = 8'($urandom);
                DATA2 = 8'($urandom);
            end
            chk({tag, " busy"}, 32'(BUSY), 32'd1);
            chk({tag, " done"}, 32'(DONE), 32'(k == lat));
            chk({tag, " result"}, 32'(RESULT), (k == lat) ? 32'(exp) : 32'(prev));
        end
        @(posedge CLK);
        #1;
        chk({tag, " busy_end"}, 32'(BUSY), 32'd0);
        chk({tag, " done_end"}, 32'(DONE), 32'd0);
        chk({tag, " result_hold"}, 32'(RESULT), 32'(exp));
    endtask

    initial begin
        logic [7:0] acc [0:8];
        RESET = 1'b0;
        START = 1'b1;
        DATA1 = 8'h5A;
        DATA2 = 8'h01;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst busy", 32'(BUSY), 32'd0);
        chk("rst done", 32'(DONE), 32'd0);
        chk("rst result", 32'(RESULT), 32'h00);
        @(negedge CLK);
        START = 1'b0;
        RESET = 1'b1;

        run_op(8'h96, 8'h03, "log3");
        run_op(8'h96, 8'h83, "rot3");
        run_op(8'h96, 8'h42, "ari2");
        run_op(8'hFF, 8'h09, "log9");
        run_op(8'h96, 8'h88, "rot8");
        run_op(8'h3C, 8'h00, "n0");
        run_op(8'hA7, 8'hC5, "pass");
        run_op(8'hC1, 8'h4F, "ari15");
        run_op(8'h81, 8'h8F, "rot15");

        // START held high: acceptances every 3 edges
        @(negedge CLK);
        START = 1'b1;
        DATA2 = 8'h02;
        DATA1 = 8'($urandom);
        for (int e = 0; e < 9; e++) begin
            acc[e] = DATA1;
            @(posedge CLK);
            #1;
            chk("hs busy", 32'(BUSY), 32'd1);
            chk("hs done", 32'(DONE), 32'(e % 3 == 2));
            if (e % 3 == 2)
                chk("hs result", 32'(RESULT), 32'(ref_model(acc[e - 2], 8'h02)));
            DATA1 = 8'($urandom);
        end
        @(negedge CLK);
        START = 1'b0;
        @(posedge CLK);
        #1;
        chk("hs busy_end", 32'(BUSY), 32'd0);
        chk("hs done_end", 32'(DONE), 32'd0);

        // reset in mid-operation
        @(negedge CLK);
        START = 1'b1;
        DATA1 = 8'h6D;
        DATA2 = 8'h05;
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("mid busy", 32'(BUSY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort busy", 32'(BUSY), 32'd0);
        chk("abort done", 32'(DONE), 32'd0);
        chk("abort result", 32'(RESULT), 32'h00);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            chk("post abort done", 32'(DONE), 32'd0);
            chk("post abort busy", 32'(BUSY), 32'd0);
        end
        run_op(8'h6D, 8'h05, "after_rst");

        for (int i = 0; i < 40; i++)
            run_op(8'($urandom), 8'($urandom), "rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
